// File: rtl/mem_data_interface.sv
// rtl/mem_data_interface.sv - 6502 memory-side data stage: MDR plus single req/ack memory transaction with timeout
module mem_data_interface #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic              mdr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic [DATA_W-1:0] out_mdr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] mdr_nxt, wdata_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              req_nxt, we_nxt, done_nxt, error_nxt;
  logic              last_wait;

  // The ack is still honoured on the final wait edge; only its absence times out.
  assign last_wait = (cnt == CNT_W'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_mdr   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_mdr   <= mdr_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_req   <= req_nxt;
      mem_we    <= we_nxt;
      done      <= done_nxt;
      error     <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mdr_nxt   = out_mdr;
    addr_nxt  = mem_addr;
    wdata_nxt = mem_wdata;
    req_nxt   = mem_req;
    we_nxt    = mem_we;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (mdr_load) mdr_nxt = data_bus_in;
        if (start_rd && start_wr) begin
          error_nxt = 1'b1;
        end else if (start_rd) begin
          addr_nxt  = addr_in;
          we_nxt    = 1'b0;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RD_WAIT;
        end else if (start_wr) begin
          addr_nxt  = addr_in;
          wdata_nxt = data_bus_in;
          we_nxt    = 1'b1;
          req_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = WR_WAIT;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (mem_ack) begin
          if (state == RD_WAIT) mdr_nxt = mem_rdata;
          req_nxt   = 1'b0;
          done_nxt  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (last_wait) begin
          req_nxt   = 1'b0;
          error_nxt = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        req_nxt   = 1'b0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_data_interface.sv
// tb/tb_mem_data_interface.sv - scoreboard bench for mem_data_interface
module tb_mem_data_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_rd = 1'b0, start_wr = 1'b0, mdr_load = 1'b0;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_bus_in = '0;
  logic [7:0]  out_mdr;
  logic        busy, done, error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_req, mem_we;
  logic        mem_ack = 1'b0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mdr;
    logic        err;
  } txn_t;

  txn_t       sb[$];
  logic [7:0] mdr_model = '0;
  int         total = 0;
  int         passed = 0;

  mem_data_interface #(.DATA_W(8), .ADDR_W(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .start_rd(start_rd), .start_wr(start_wr),
    .mdr_load(mdr_load), .addr_in(addr_in), .data_bus_in(data_bus_in),
    .out_mdr(out_mdr), .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if ({out_mdr, busy, done, error, mem_req, mem_we} !== 13'h0) $display("FAIL reset_outputs got %h exp 0", {out_mdr, busy, done, error, mem_req, mem_we}); else passed++;
    total++; if ({mem_addr, mem_wdata} !== 24'h0) $display("FAIL reset_bus got %h exp 0", {mem_addr, mem_wdata}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mdr_load();
    mdr_load = 1'b1; data_bus_in = 8'h77;
    tick();
    mdr_load = 1'b0; mdr_model = 8'h77;
    total++; if (out_mdr !== mdr_model) $display("FAIL mdr_load got %h exp %h", out_mdr, mdr_model); else passed++;
    total++; if (mem_req !== 1'b0) $display("FAIL mdr_load_req got %b exp 0", mem_req); else passed++;
  endtask

  task automatic test_read();
    txn_t t;
    int   cyc;
    t.we = 1'b0; t.addr = 16'h1234; t.wdata = mem_wdata; t.mdr = 8'hA5; t.err = 1'b0;
    sb.push_back(t);
    start_rd = 1'b1; addr_in = 16'h1234;
    tick(); start_rd = 1'b0; cyc = 1;
    total++; if ({mem_req, mem_we, busy} !== 3'b101) $display("FAIL rd_req got req=%b we=%b busy=%b exp 1 0 1", mem_req, mem_we, busy); else passed++;
    total++; if (mem_addr !== 16'h1234) $display("FAIL rd_addr got %h exp 1234", mem_addr); else passed++;
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick(); mem_ack = 1'b0; cyc++;
    t = sb.pop_front();
    mdr_model = t.mdr;
    total++; if ({done, error, mem_req} !== 3'b100 || cyc != 2) $display("FAIL rd_done got done=%b err=%b req=%b cyc=%0d exp 1 0 0 2", done, error, mem_req, cyc); else passed++;
    total++; if (out_mdr !== t.mdr) $display("FAIL rd_mdr got %h exp %h", out_mdr, t.mdr); else passed++;
    tick();
    total++; if ({done, busy, mem_addr} !== {2'b00, t.addr}) $display("FAIL rd_after got done=%b busy=%b addr=%h exp 0 0 %h", done, busy, mem_addr, t.addr); else passed++;
  endtask

  task automatic test_write();
    txn_t t;
    int   req_cycles = 0;
    int   done_cnt = 0;
    t.we = 1'b1; t.addr = 16'h01FF; t.wdata = 8'h3C; t.mdr = mdr_model; t.err = 1'b0;
    sb.push_back(t);
    start_wr = 1'b1; addr_in = 16'h01FF; data_bus_in = 8'h3C;
    tick(); start_wr = 1'b0; data_bus_in = 8'h00;
    total++; if ({mem_we, mem_wdata, mem_addr} !== {t.we, t.wdata, t.addr}) $display("FAIL wr_bus got we=%b wd=%h a=%h exp %b %h %h", mem_we, mem_wdata, mem_addr, t.we, t.wdata, t.addr); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) req_cycles++;
      mem_ack = (i == 3);
      tick();
      if (done) done_cnt++;
    end
    mem_ack = 1'b0;
    t = sb.pop_front();
    tick();
    if (done) done_cnt++;
    total++; if (req_cycles != 4 || mem_req !== 1'b0) $display("FAIL wr_req_len got %0d req=%b exp 4 0", req_cycles, mem_req); else passed++;
    total++; if (done_cnt != 1) $display("FAIL wr_done_count got %0d exp 1", done_cnt); else passed++;
    total++; if (out_mdr !== t.mdr || mem_wdata !== t.wdata) $display("FAIL wr_hold got mdr=%h wd=%h exp %h %h", out_mdr, mem_wdata, t.mdr, t.wdata); else passed++;
  endtask

  task automatic test_timeout();
    txn_t t;
    int   n = 0;
    t.we = 1'b0; t.addr = 16'h4000; t.wdata = mem_wdata; t.mdr = mdr_model; t.err = 1'b1;
    sb.push_back(t);
    start_rd = 1'b1; addr_in = 16'h4000; mem_rdata = 8'hEE;
    tick(); start_rd = 1'b0;
    while (mem_req && n < 40) begin
      n++;
      total++; if (done !== 1'b0) $display("FAIL to_no_done got %b exp 0 at %0d", done, n); else passed++;
      tick();
    end
    t = sb.pop_front();
    total++; if (n != 15) $display("FAIL to_req_len got %0d exp 15", n); else passed++;
    total++; if ({error, done, busy} !== {t.err, 2'b00}) $display("FAIL to_error got err=%b done=%b busy=%b exp 1 0 0", error, done, busy); else passed++;
    total++; if (out_mdr !== t.mdr) $display("FAIL to_mdr got %h exp %h", out_mdr, t.mdr); else passed++;
    tick();
    total++; if (error !== 1'b0) $display("FAIL to_error_pulse got %b exp 0", error); else passed++;
  endtask

  task automatic test_ack_last();
    txn_t t;
    t.we = 1'b0; t.addr = 16'h4001; t.wdata = mem_wdata; t.mdr = 8'h5A; t.err = 1'b0;
    sb.push_back(t);
    start_rd = 1'b1; addr_in = 16'h4001;
    tick(); start_rd = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++; if (mem_req !== 1'b1) $display("FAIL ack15_req got %b exp 1", mem_req); else passed++;
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick(); mem_ack = 1'b0;
    t = sb.pop_front();
    mdr_model = t.mdr;
    total++; if ({done, error} !== {1'b1, t.err}) $display("FAIL ack15_done got done=%b err=%b exp 1 0", done, error); else passed++;
    total++; if (out_mdr !== t.mdr) $display("FAIL ack15_mdr got %h exp %h", out_mdr, t.mdr); else passed++;
    tick();
  endtask

  task automatic test_illegal_start();
    start_rd = 1'b1; start_wr = 1'b1; addr_in = 16'h9999;
    tick(); start_rd = 1'b0; start_wr = 1'b0;
    total++; if ({mem_req, busy, error} !== 3'b001) $display("FAIL both_start got req=%b busy=%b err=%b exp 0 0 1", mem_req, busy, error); else passed++;
    tick();
    total++; if ({mem_req, error} !== 2'b00) $display("FAIL both_start_after got req=%b err=%b exp 0 0", mem_req, error); else passed++;
  endtask

  task automatic test_busy_ignore();
    txn_t t;
    t.we = 1'b0; t.addr = 16'h2222; t.wdata = mem_wdata; t.mdr = 8'hC3; t.err = 1'b0;
    sb.push_back(t);
    start_rd = 1'b1; addr_in = 16'h2222;
    tick();
    addr_in = 16'hBEEF; mdr_load = 1'b1; data_bus_in = 8'h11;
    tick();
    start_rd = 1'b0; mdr_load = 1'b0;
    total++; if (mem_addr !== t.addr || out_mdr !== mdr_model) $display("FAIL busy_ignore got a=%h mdr=%h exp %h %h", mem_addr, out_mdr, t.addr, mdr_model); else passed++;
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick(); mem_ack = 1'b0;
    t = sb.pop_front();
    mdr_model = t.mdr;
    total++; if (done !== 1'b1 || out_mdr !== t.mdr) $display("FAIL busy_done got done=%b mdr=%h exp 1 %h", done, out_mdr, t.mdr); else passed++;
    tick();
    total++; if ({mem_req, busy} !== 2'b00) $display("FAIL busy_not_queued got req=%b busy=%b exp 0 0", mem_req, busy); else passed++;
  endtask

  task automatic test_back_to_back();
    start_rd = 1'b1; addr_in = 16'h3000;
    tick(); start_rd = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h42;
    tick(); mem_ack = 1'b0;
    mdr_model = 8'h42;
    total++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b exp 1", done); else passed++;
    start_wr = 1'b1; addr_in = 16'h3001; data_bus_in = 8'h99;
    tick(); start_wr = 1'b0;
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h3001, 8'h99}) $display("FAIL b2b_second got req=%b we=%b a=%h wd=%h exp 1 1 3001 99", mem_req, mem_we, mem_addr, mem_wdata); else passed++;
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    total++; if (done !== 1'b1 || out_mdr !== mdr_model) $display("FAIL b2b_second_done got done=%b mdr=%h exp 1 %h", done, out_mdr, mdr_model); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    start_rd = 1'b1; addr_in = 16'h5555;
    tick(); start_rd = 1'b0;
    tick();
    rst_n = 1'b0;
    sb.delete();
    mdr_model = 8'h00;
    #1;
    total++; if ({mem_req, busy, out_mdr} !== 10'h0) $display("FAIL rst_mid got req=%b busy=%b mdr=%h exp 0 0 00", mem_req, busy, out_mdr); else passed++;
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hFF;
    tick(); mem_ack = 1'b0;
    if (done || error) done_seen++;
    tick();
    if (done || error) done_seen++;
    total++; if (done_seen != 0 || out_mdr !== mdr_model) $display("FAIL rst_late_ack got pulses=%0d mdr=%h exp 0 %h", done_seen, out_mdr, mdr_model); else passed++;
  endtask

  initial begin
    test_reset();
    test_mdr_load();
    test_read();
    test_write();
    test_timeout();
    test_ack_last();
    test_illegal_start();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    total++; if (sb.size() != 0) $display("FAIL scoreboard_left got %0d exp 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
